// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared widths, requester indices and ROM address record for the digit-glyph ROM
package snake_pkg;
  localparam int NUMBER_SEL_W        = 4;
  localparam int NUMBER_CNT_W        = 8;
  localparam int REQ_TIME            = 0;
  localparam int REQ_SCORE           = 1;
  localparam int ROM_LATENCY_DEFAULT = 1;

  typedef struct packed {
    logic [NUMBER_SEL_W-1:0] number;
    logic [NUMBER_CNT_W-1:0] count;
  } rom_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with a last-winner pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt
);
  localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] r_last_ptr;
  logic [PTR_W-1:0] w_win;
  logic             w_found;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Search starts just after the last winner, so the previous winner is checked last.
  always_comb begin
    w_win   = r_last_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && i_req[wrap_add(r_last_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_last_ptr, k);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (w_found && !i_clear && rst_n) o_gnt[w_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ptr <= PTR_INIT;
    end else if (i_clear) begin
      r_last_ptr <= PTR_INIT;
    end else if (w_found) begin
      r_last_ptr <= w_win;
    end
  end
endmodule

// File: rtl/number_rom_arbiter.sv
// rtl/number_rom_arbiter.sv - shares the digit-glyph ROM between number renderers, tags returned pixels
// Optional: NUMBER_ARB_OVERLAP_ERR_EN adds the sticky overlap_err output.
module number_rom_arbiter
  import snake_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int ROM_LATENCY      = ROM_LATENCY_DEFAULT,
  parameter int CONFLICT_CNT_BIT = 8
) (
  input  logic                                clock_25,
  input  logic                                reset,
  input  logic                                sync_reset,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUMBER_SEL_W*NUM_REQ-1:0]     sel_number,
  input  logic [NUMBER_CNT_W*NUM_REQ-1:0]     sel_count,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [NUMBER_SEL_W-1:0]             rom_number,
  output logic [NUMBER_CNT_W-1:0]             rom_count,
  input  logic                                number_pixel,
  output logic                                pixel_out,
  output logic                                pixel_valid,
  output logic [NUM_REQ-1:0]                  pixel_owner,
  output logic [CONFLICT_CNT_BIT*NUM_REQ-1:0] conflict_cnt
`ifdef NUMBER_ARB_OVERLAP_ERR_EN
  ,
  output logic                                overlap_err
`endif
);
  logic                        w_xfer;
  rom_addr_t                   w_addr;
  rom_addr_t                   r_addr;
  logic [ROM_LATENCY:0]        r_tag_valid;
  logic [NUM_REQ-1:0]          r_tag_owner [ROM_LATENCY+1];
  logic [CONFLICT_CNT_BIT-1:0] r_conflict  [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk     (clock_25),
    .rst_n   (reset),
    .i_clear (sync_reset),
    .i_req   (req),
    .o_gnt   (gnt)
  );

  assign w_xfer = |(req & gnt);

  always_comb begin
    w_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        w_addr.number = sel_number[NUMBER_SEL_W*i +: NUMBER_SEL_W];
        w_addr.count  = sel_count[NUMBER_CNT_W*i +: NUMBER_CNT_W];
      end
    end
  end

  // w_addr is already zero without a grant, giving the idle address.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
    end else if (sync_reset) begin
      r_addr <= '0;
    end else begin
      r_addr <= w_addr;
    end
  end

  assign rom_number = r_addr.number;
  assign rom_count  = r_addr.count;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_tag_valid <= '0;
      for (int s = 0; s <= ROM_LATENCY; s++) r_tag_owner[s] <= '0;
    end else if (sync_reset) begin
      r_tag_valid <= '0;
      for (int s = 0; s <= ROM_LATENCY; s++) r_tag_owner[s] <= '0;
    end else begin
      for (int s = ROM_LATENCY; s >= 1; s--) begin
        r_tag_valid[s] <= r_tag_valid[s-1];
        r_tag_owner[s] <= r_tag_owner[s-1];
      end
      r_tag_valid[0] <= w_xfer;
      r_tag_owner[0] <= gnt;
    end
  end

  // A lookup emerging during a restart is discarded along with those still in flight.
  assign pixel_valid = r_tag_valid[ROM_LATENCY] & ~sync_reset;
  assign pixel_owner = pixel_valid ? r_tag_owner[ROM_LATENCY] : '0;
  assign pixel_out   = number_pixel & pixel_valid;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_conflict[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sync_reset) begin
          r_conflict[i] <= '0;
        end else if (req[i] && !gnt[i] && !(&r_conflict[i])) begin
          r_conflict[i] <= r_conflict[i] + CONFLICT_CNT_BIT'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    assign conflict_cnt[CONFLICT_CNT_BIT*gi +: CONFLICT_CNT_BIT] = r_conflict[gi];
  end

`ifdef NUMBER_ARB_OVERLAP_ERR_EN
  logic r_overlap_err;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_overlap_err <= 1'b0;
    end else if (sync_reset) begin
      r_overlap_err <= 1'b0;
    end else if ($countones(req) > 1) begin
      r_overlap_err <= 1'b1;
    end
  end

  assign overlap_err = r_overlap_err;
`endif
endmodule

// File: tb/tb_number_rom_arbiter.sv
// tb/tb_number_rom_arbiter.sv - self-checking bench: vector table, directed corner cases, random vs reference model
module tb_number_rom_arbiter;
  import snake_pkg::*;

  localparam int NR  = 2;
  localparam int LAT = 1;

  logic        clock_25     = 1'b0;
  logic        reset        = 1'b0;
  logic        sync_reset   = 1'b0;
  logic [1:0]  req          = '0;
  logic [7:0]  sel_number   = '0;
  logic [15:0] sel_count    = '0;
  logic        number_pixel = 1'b0;
  logic [1:0]  gnt;
  logic [3:0]  rom_number;
  logic [7:0]  rom_count;
  logic        pixel_out;
  logic        pixel_valid;
  logic [1:0]  pixel_owner;
  logic [15:0] conflict_cnt;
`ifdef NUMBER_ARB_OVERLAP_ERR_EN
  logic        overlap_err;
`endif

  always #20 clock_25 = ~clock_25;

  number_rom_arbiter dut (
    .clock_25     (clock_25),
    .reset        (reset),
    .sync_reset   (sync_reset),
    .req          (req),
    .sel_number   (sel_number),
    .sel_count    (sel_count),
    .gnt          (gnt),
    .rom_number   (rom_number),
    .rom_count    (rom_count),
    .number_pixel (number_pixel),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .pixel_owner  (pixel_owner),
    .conflict_cnt (conflict_cnt)
`ifdef NUMBER_ARB_OVERLAP_ERR_EN
    ,
    .overlap_err  (overlap_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pointer to last winner, counters, expected address, per-cycle history.
  int         m_ptr = NR - 1;
  int         m_cnt [NR];
  logic [3:0] m_rn  = '0;
  logic [7:0] m_rc  = '0;
  logic       m_ovl = 1'b0;
  logic [1:0] m_gnt = '0;
  bit         h_xfer [$];
  int         h_owner[$];
  bit         h_clr  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, h_xfer.size(), act, exp);
    end
  endtask

  task automatic step(input logic rst_v, input logic [1:0] rq, input logic [7:0] sn,
                      input logic [15:0] sc, input logic sy, input logic px);
    int         n;
    int         win;
    logic       clr;
    logic       ev;
    logic [1:0] eo;
    @(posedge clock_25);
    #1;
    reset = rst_v; req = rq; sel_number = sn; sel_count = sc; sync_reset = sy; number_pixel = px;
    @(negedge clock_25);
    n   = h_xfer.size();
    clr = sy || !rst_v;
    win = -1;
    if (!clr) begin
      for (int k = 1; k <= NR; k++) begin
        if (win < 0 && rq[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      end
    end
    m_gnt = (win >= 0) ? 2'(1 << win) : 2'b00;
    ev = 1'b0;
    eo = 2'b00;
    if (n >= LAT + 1 && !clr && h_xfer[n-LAT-1]) begin
      ev = 1'b1;
      for (int j = n - LAT; j < n; j++) if (h_clr[j]) ev = 1'b0;
      if (ev) eo = 2'(1 << h_owner[n-LAT-1]);
    end
    if (!rst_v) begin
      m_rn = '0; m_rc = '0; m_ovl = 1'b0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("rom_number", 32'(rom_number), 32'(m_rn));
    chk("rom_count", 32'(rom_count), 32'(m_rc));
    chk("pixel_valid", 32'(pixel_valid), 32'(ev));
    chk("pixel_owner", 32'(pixel_owner), 32'(eo));
    chk("pixel_out", 32'(pixel_out), 32'(px & ev));
    chk("cnt_time", 32'(conflict_cnt[8*REQ_TIME +: 8]), 32'(m_cnt[REQ_TIME]));
    chk("cnt_score", 32'(conflict_cnt[8*REQ_SCORE +: 8]), 32'(m_cnt[REQ_SCORE]));
`ifdef NUMBER_ARB_OVERLAP_ERR_EN
    chk("overlap_err", 32'(overlap_err), 32'(m_ovl));
`endif
    if (clr) begin
      m_ptr = NR - 1; m_rn = '0; m_rc = '0; m_ovl = 1'b0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < NR; i++) if (rq[i] && !m_gnt[i] && m_cnt[i] < 255) m_cnt[i]++;
      if (win >= 0) begin
        m_ptr = win;
        m_rn  = sn[4*win +: 4];
        m_rc  = sc[8*win +: 8];
      end else begin
        m_rn = '0;
        m_rc = '0;
      end
      if (rq == 2'b11) m_ovl = 1'b1;
    end
    h_xfer.push_back(win >= 0);
    h_owner.push_back(win);
    h_clr.push_back(clr);
  endtask

  typedef struct {
    logic [1:0]  rq;
    logic [7:0]  sn;
    logic [15:0] sc;
    logic        sy;
    logic [1:0]  e_gnt;
    logic [3:0]  e_rn;
    logic [7:0]  e_rc;
    logic        e_pv;
    logic [1:0]  e_po;
    logic [7:0]  e_c0;
    logic [7:0]  e_c1;
  } vec_t;

  vec_t tbl [15];

  logic       pend [NR];
  logic [3:0] psn  [NR];
  logic [7:0] psc  [NR];

  initial begin
    int nvalid;
    int run;
    int maxrun;
    tbl[0]  = '{2'b01, 8'h05, 16'h002A, 1'b0, 2'b01, 4'h0, 8'h00, 1'b0, 2'b00, 8'd0, 8'd0};
    tbl[1]  = '{2'b00, 8'h00, 16'h0000, 1'b0, 2'b00, 4'h5, 8'h2A, 1'b0, 2'b00, 8'd0, 8'd0};
    tbl[2]  = '{2'b00, 8'h00, 16'h0000, 1'b0, 2'b00, 4'h0, 8'h00, 1'b1, 2'b01, 8'd0, 8'd0};
    tbl[3]  = '{2'b00, 8'h00, 16'h0000, 1'b1, 2'b00, 4'h0, 8'h00, 1'b0, 2'b00, 8'd0, 8'd0};
    tbl[4]  = '{2'b11, 8'h35, 16'h7711, 1'b0, 2'b01, 4'h0, 8'h00, 1'b0, 2'b00, 8'd0, 8'd0};
    tbl[5]  = '{2'b11, 8'h35, 16'h7711, 1'b0, 2'b10, 4'h5, 8'h11, 1'b0, 2'b00, 8'd0, 8'd1};
    tbl[6]  = '{2'b11, 8'h35, 16'h7711, 1'b0, 2'b01, 4'h3, 8'h77, 1'b1, 2'b01, 8'd1, 8'd1};
    tbl[7]  = '{2'b11, 8'h35, 16'h7711, 1'b0, 2'b10, 4'h5, 8'h11, 1'b1, 2'b10, 8'd1, 8'd2};
    tbl[8]  = '{2'b00, 8'h00, 16'h0000, 1'b0, 2'b00, 4'h3, 8'h77, 1'b1, 2'b01, 8'd2, 8'd2};
    tbl[9]  = '{2'b00, 8'h00, 16'h0000, 1'b0, 2'b00, 4'h0, 8'h00, 1'b1, 2'b10, 8'd2, 8'd2};
    tbl[10] = '{2'b10, 8'h90, 16'h4400, 1'b0, 2'b10, 4'h0, 8'h00, 1'b0, 2'b00, 8'd2, 8'd2};
    tbl[11] = '{2'b10, 8'h90, 16'h4400, 1'b0, 2'b10, 4'h9, 8'h44, 1'b0, 2'b00, 8'd2, 8'd2};
    tbl[12] = '{2'b10, 8'h90, 16'h4400, 1'b1, 2'b00, 4'h9, 8'h44, 1'b0, 2'b00, 8'd2, 8'd2};
    tbl[13] = '{2'b00, 8'h00, 16'h0000, 1'b0, 2'b00, 4'h0, 8'h00, 1'b0, 2'b00, 8'd0, 8'd0};
    tbl[14] = '{2'b00, 8'h00, 16'h0000, 1'b0, 2'b00, 4'h0, 8'h00, 1'b0, 2'b00, 8'd0, 8'd0};
    for (int i = 0; i < NR; i++) begin
      m_cnt[i] = 0; pend[i] = 1'b0; psn[i] = '0; psc[i] = '0;
    end

    step(1'b0, 2'b11, 8'hFF, 16'hFFFF, 1'b0, 1'b1);
    step(1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 1'b0);

    for (int t = 0; t < 15; t++) begin
      step(1'b1, tbl[t].rq, tbl[t].sn, tbl[t].sc, tbl[t].sy, 1'b1);
      chk($sformatf("tbl%0d_gnt", t), 32'(gnt), 32'(tbl[t].e_gnt));
      chk($sformatf("tbl%0d_rom_number", t), 32'(rom_number), 32'(tbl[t].e_rn));
      chk($sformatf("tbl%0d_rom_count", t), 32'(rom_count), 32'(tbl[t].e_rc));
      chk($sformatf("tbl%0d_pixel_valid", t), 32'(pixel_valid), 32'(tbl[t].e_pv));
      chk($sformatf("tbl%0d_pixel_owner", t), 32'(pixel_owner), 32'(tbl[t].e_po));
      chk($sformatf("tbl%0d_pixel_out", t), 32'(pixel_out), 32'(tbl[t].e_pv));
      chk($sformatf("tbl%0d_cnt0", t), 32'(conflict_cnt[7:0]), 32'(tbl[t].e_c0));
      chk($sformatf("tbl%0d_cnt1", t), 32'(conflict_cnt[15:8]), 32'(tbl[t].e_c1));
    end

    // Single requester streaming with an alternating ROM pattern.
    nvalid = 0; run = 0; maxrun = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, (k < 10) ? 2'b10 : 2'b00, 8'h70, 16'(k) << 8, 1'b0, k[0]);
      if (pixel_valid) begin
        nvalid++;
        run++;
        if (run > maxrun) maxrun = run;
        chk("stream_owner", 32'(pixel_owner), 32'h2);
      end else begin
        run = 0;
      end
    end
    chk("stream_valid_count", 32'(nvalid), 32'd10);
    chk("stream_no_bubble", 32'(maxrun), 32'd10);

    // Saturation of both conflict counters.
    for (int k = 0; k < 520; k++) step(1'b1, 2'b11, 8'h21, 16'h0301, 1'b0, 1'b0);
    chk("sat_cnt0", 32'(conflict_cnt[7:0]), 32'd255);
    chk("sat_cnt1", 32'(conflict_cnt[15:8]), 32'd255);
    step(1'b1, 2'b11, 8'h21, 16'h0301, 1'b0, 1'b0);
    step(1'b1, 2'b00, 8'h00, 16'h0000, 1'b0, 1'b0);
    chk("sat_hold_cnt0", 32'(conflict_cnt[7:0]), 32'd255);
    chk("sat_hold_cnt1", 32'(conflict_cnt[15:8]), 32'd255);

`ifdef NUMBER_ARB_OVERLAP_ERR_EN
    step(1'b1, 2'b00, 8'h00, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 2'b11, 8'h12, 16'h3456, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'b00, 8'h00, 16'h0000, 1'b0, 1'b0);
      chk("ovl_sticky", 32'(overlap_err), 32'd1);
    end
    step(1'b1, 2'b00, 8'h00, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 2'b00, 8'h00, 16'h0000, 1'b0, 1'b0);
    chk("ovl_cleared", 32'(overlap_err), 32'd0);
`endif

    // Asynchronous reset with lookups in flight leaves nothing behind.
    step(1'b1, 2'b01, 8'h06, 16'h0033, 1'b0, 1'b1);
    step(1'b1, 2'b10, 8'h70, 16'h4400, 1'b0, 1'b1);
    step(1'b0, 2'b11, 8'h76, 16'h4433, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'b00, 8'h00, 16'h0000, 1'b0, 1'b1);
      chk("post_reset_no_pixel", 32'(pixel_valid), 32'd0);
    end

    for (int c = 0; c < 1500; c++) begin
      logic [1:0]  rq;
      logic [7:0]  sn;
      logic [15:0] sc;
      logic        sy;
      logic        rv;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          psn[i]  = 4'($urandom);
          psc[i]  = 8'($urandom);
        end
      end
      rq = {pend[1], pend[0]};
      sn = {psn[1], psn[0]};
      sc = {psc[1], psc[0]};
      sy = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 299) != 0);
      step(rv, rq, sn, sc, sy, 1'($urandom));
      for (int i = 0; i < NR; i++) if (m_gnt[i]) pend[i] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/number_rom_arbiter.md
Name: number_rom_arbiter

Overview:
- Shares the single digit-glyph ROM (`numbers`) between the on-screen number renderers: requester 0 = time_controller, requester 1 = score_controller.
- Replaces the OR-merge of their select/count buses with a req/gnt round-robin arbiter.
- Registers the winning ROM address and tracks each lookup through the ROM latency, so every returned pixel is tagged with its owner.
- Sustains one lookup per clock_25 cycle.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- ROM_LATENCY, 1: clock cycles from the rom_number/rom_count registers to a valid number_pixel.
- CONFLICT_CNT_BIT, 8: width of the saturating per-requester conflict counters.

Ports:
- clock_25  input  1  system clock (25 MHz pixel clock).
- reset  input  1  asynchronous, active-low reset.
- sync_reset  input  1  synchronous game restart; flushes the pipeline.
- req  input  NUM_REQ  per-requester lookup request.
- sel_number  input  4*NUM_REQ  digit index per requester; requester i uses bits [4i+3:4i].
- sel_count  input  8*NUM_REQ  glyph row/column address per requester; requester i uses bits [8i+7:8i].
- gnt  output  NUM_REQ  one-hot, combinational; the request is accepted this cycle.
- rom_number  output  4  registered digit index to the ROM.
- rom_count  output  8  registered glyph address to the ROM.
- number_pixel  input  1  ROM data.
- pixel_out  output  1  returned pixel; forced to 0 when pixel_valid = 0.
- pixel_valid  output  1  pixel_out is valid.
- pixel_owner  output  NUM_REQ  one-hot owner of pixel_out.
- conflict_cnt  output  CONFLICT_CNT_BIT*NUM_REQ  saturating count of cycles each requester was refused.

Behaviour:
- Reset (reset = 0, asynchronous): all outputs 0, the tag pipeline is empty, and last_ptr = NUM_REQ-1, so requester 0 wins the first conflict.
- Handshake:
  - A transfer occurs when req[i] & gnt[i].
  - A refused requester must hold req and its buses stable until granted.
  - gnt is never asserted without req.
- Arbitration:
  - At most one grant per cycle.
  - Round-robin search starts at last_ptr+1, wrapping modulo NUM_REQ.
  - last_ptr updates to the winner only on a transfer.
  - With a single requester asserting, it is granted every cycle and there is no bubble.
- Address stage:
  - On a transfer, the next edge loads rom_number/rom_count from the winner's slices.
  - With no transfer, both registers load 0 (idle address).
- Tag pipeline:
  - Shift register of depth ROM_LATENCY+1 holding {valid, owner}; stage 0 loads {transfer, gnt}.
  - pixel_valid/pixel_owner come from the last stage.
  - pixel_out = number_pixel & pixel_valid.
  - Latency is exactly ROM_LATENCY+1 cycles from the transfer cycle to pixel_valid.
- Conflict counting: each cycle where req[i] = 1 and gnt[i] = 0 increments conflict_cnt slice i, saturating at all-ones.
- sync_reset (synchronous, highest priority over normal update):
  - Clears the tag pipeline, rom_number, rom_count and the conflict counters.
  - Resets last_ptr to NUM_REQ-1.
  - Forces gnt = 0 that cycle; requests arriving in the same cycle are dropped.
  - In-flight lookups are discarded, with no pixel_valid for them.
- Reset mid-operation: asynchronous clear as above; there is no partial output after reset releases.
- Simultaneous events: refusal and increment happen in the same cycle, and the next cycle grants the refused requester (fairness bound = NUM_REQ-1 cycles wait).

Optional Feature:
- Macro: NUMBER_ARB_OVERLAP_ERR_EN.
- When defined, adds output port overlap_err (1 bit):
  - Sticky; set on the first cycle with more than one req bit asserted.
  - Cleared only by reset or sync_reset.
  - Flags overlapping time/score screen windows.
- When undefined, the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (snake_pkg) holds:
  - NUMBER_SEL_W = 4 and NUMBER_CNT_W = 8.
  - Requester index constants REQ_TIME = 0 and REQ_SCORE = 1.
  - The default ROM_LATENCY.
- One natural sub-module: rr_arbiter, covering the grant one-hot, last_ptr and wrap logic.
- The tag pipeline and counters stay in the top module.

Test Plan:
- After reset release, req = 01, sel_number[3:0] = 5, sel_count[7:0] = 8'h2A:
  - gnt = 01 the same cycle.
  - rom_number = 5, rom_count = 8'h2A next cycle.
  - pixel_valid = 1 and pixel_owner = 01 two cycles after the request (ROM_LATENCY = 1).
- req = 11 held for 4 cycles → gnt sequence 01, 10, 01, 10; each requester's conflict_cnt = 2.
- req = 10 continuously for 10 cycles, ROM model returning alternating bits → 10 consecutive pixel_valid cycles, all with owner 10, with no bubbles.
- Transfers in 2 consecutive cycles, then sync_reset pulsed the next cycle → no pixel_valid for either, and all counters read 0.
- Drive conflict_cnt to 255 with CONFLICT_CNT_BIT = 8, then one more refusal → stays at 255.
- With NUMBER_ARB_OVERLAP_ERR_EN defined:
  - req = 11 for one cycle, then req = 00 → overlap_err = 1 and stays 1.
  - sync_reset clears overlap_err to 0.
